core_hazard_ctrl: RTL

Pipeline scheduler for the five-stage RV64IM core. It detects load-use hazards, taken branches resolved in ID, and multi-cycle M-extension operations in EX. From these it drives the write-enable and flush controls of the PC and the IF/ID, ID/EX and EX/MEM registers, replacing the tied-high `pc_wen` of the current core. It sits beside `core_ctrl` and observes the ID and EX stages only.

---
 rtl/core_hazard_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/core_hazard_ctrl.sv
// Hazard scheduler for the five-stage RV64IM pipeline: load-use stalls, ID branch flushes, MUL/DIV holds.
// Optional performance counters are built when CORE_HZD_PERF_CNT_EN is defined.
module core_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned RFIDX_W         = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RFIDX_W-1:0] id_rs1_idx,
  input  logic [RFIDX_W-1:0] id_rs2_idx,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic               id_branch_taken,
  input  logic [RFIDX_W-1:0] ex_rsd_idx,
  input  logic               ex_mem_read,
  input  logic               ex_md_valid,
  input  logic               md_done,
  output logic               md_start,
  output logic               pc_wen,
  output logic               if_id_wen,
  output logic               id_ex_wen,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               ex_mem_flush,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
);

  localparam int unsigned LU_CNT_W = 2;
  localparam int unsigned CNT_W    = 32;
  localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LU_STALL_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MD_WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic                lu_hit;

  // Load-use: the ID instruction reads the register the EX load is about to write.
  always_comb begin
    lu_hit = ex_mem_read && (ex_rsd_idx != '0) &&
             ((id_rs1_used && (id_rs1_idx == ex_rsd_idx)) ||
              (id_rs2_used && (id_rs2_idx == ex_rsd_idx)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    md_start     = 1'b0;
    pc_wen       = 1'b1;
    if_id_wen    = 1'b1;
    id_ex_wen    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    if (!rst_n) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
      lu_cnt_d     = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_md_valid) begin
            // The MD instruction is held in EX from its start cycle onward; md_done here is ignored.
            md_start     = 1'b1;
            pc_wen       = 1'b0;
            if_id_wen    = 1'b0;
            id_ex_wen    = 1'b0;
            ex_mem_flush = 1'b1;
            state_d      = MD_WAIT;
          end else if (lu_hit) begin
            pc_wen      = 1'b0;
            if_id_wen   = 1'b0;
            id_ex_flush = 1'b1;
            lu_cnt_d    = LU_RELOAD;
            if (LU_RELOAD != '0) begin
              state_d = LU_STALL;
            end
          end else if (id_branch_taken) begin
            if_id_flush = 1'b1;
          end
        end

        LU_STALL: begin
          // Branch outcome is computed from stale operands here, so it is not acted on.
          pc_wen      = 1'b0;
          if_id_wen   = 1'b0;
          id_ex_flush = 1'b1;
          lu_cnt_d    = lu_cnt_q - LU_CNT_W'(1);
          if (lu_cnt_q == LU_CNT_W'(1)) begin
            state_d = RUN;
          end
        end

        MD_WAIT: begin
          pc_wen    = 1'b0;
          if_id_wen = 1'b0;
          id_ex_wen = 1'b0;
          if (md_done) begin
            state_d = RUN;
          end else begin
            ex_mem_flush = 1'b1;
          end
        end

        default: begin
          state_d  = RUN;
          lu_cnt_d = '0;
        end
      endcase
    end
  end

`ifdef CORE_HZD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating stall and front-end flush counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_wen && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (if_id_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = CNT_W'(0);
  assign flush_cnt = CNT_W'(0);
`endif

endmodule
